h80cpu_bus_arb: RTL and testbench
=================================

H80CPU_BUS_ARB -- requirements
Module: h80cpu_bus_arb

Interface
Parameters
REQ-001 Parameter IO_BASE, default 'hFF00; base address of the I/O window.
REQ-002 Parameter IO_MASK, default 'hFF00; address bits compared against IO_BASE.
REQ-003 Parameter TIMEOUT, default 255; maximum wait-state cycles before an access is aborted.

Ports
REQ-004 The block SHALL have exactly one clock and a synchronous, active-high reset: clk input 1 system clock; reset input 1 synchronous active-high reset.
REQ-005 m_req input 2; per-requester access request (index 0 = CPU, 1 = DMA/debug).
REQ-006 m_addr input 2 x bus_addr_t; per-requester address.
REQ-007 m_cmd input 2 x bus_cmd_t; per-requester command.
REQ-008 m_wdata input 2 x bus_data_t; per-requester write data.
REQ-009 m_gnt output 2; one-hot grant, high while the access is owned.
REQ-010 m_done output 2; one-cycle completion pulse to the owner.
REQ-011 m_err output 1; valid with m_done, high on timeout abort.
REQ-012 rdata output bus_data_t; read data, valid with m_done.
REQ-013 mem_ce_n output 1; active-low memory chip enable.
REQ-014 io_ce_n output 1; active-low I/O chip enable.
REQ-015 addr output bus_addr_t; shared slave address.
REQ-016 cmd output bus_cmd_t; shared slave command.
REQ-017 data inout bus_data_t; shared slave data bus.
REQ-018 wait_n input 1; wired-AND slave ready, low = insert wait.

Function
REQ-019 States: IDLE, ACCESS, DONE.
REQ-020 IDLE: on any m_req, select the winner, latch its addr/cmd/wdata and go to ACCESS on the next edge.
REQ-021 Arbitration: round-robin; the last owner gets lowest priority; after reset requester 0 has priority.
REQ-022 Decode: io_ce_n is low when (addr & IO_MASK) == IO_BASE, otherwise mem_ce_n is low; never both low.
REQ-023 ACCESS: the decoded ce_n is low; addr/cmd are stable from the latch; data is driven with wdata for write commands and high-Z otherwise.
REQ-024 ACCESS: wait_n is sampled each edge; if high, capture data into rdata and go to DONE.
REQ-025 Wait-state counter: 8 bits, cleared on entering ACCESS, incremented per low-wait_n cycle; on reaching TIMEOUT go to DONE with m_err=1 and rdata unchanged.
REQ-026 DONE: both ce_n high, data high-Z, cmd idle, m_done pulsed for the owner for exactly one cycle, priority updated, return to IDLE.
REQ-027 Zero-wait latency: m_req seen at edge N gives ce_n low during cycle N+1 and m_done during cycle N+2; the minimum back-to-back access period is 3 cycles.
REQ-028 m_gnt is high for the owner during ACCESS and DONE only.
REQ-029 m_req dropped mid-access: the access still completes and m_done still pulses.
REQ-030 Requests arriving during ACCESS/DONE are held off until IDLE; no request is lost while m_req stays high.

Reset
REQ-031 While reset is high, at the next edge: state=IDLE, mem_ce_n=io_ce_n=1, data high-Z, cmd idle, m_gnt=0, m_done=0, m_err=0, rdata=0, priority to requester 0.
REQ-032 Reset mid-access SHALL abort the access with no m_done pulse.

Structure
REQ-033 bus_addr_t, bus_cmd_t (including the idle and write/read byte commands) and bus_data_t SHALL come from the shared h80cpu bus package; the state enum SHALL be local.
REQ-034 Address decode SHALL be a sub-module, h80cpu_bus_decode (combinational, parameterized by IO_BASE and IO_MASK).

Verification
REQ-035 Single CPU write_b to 'h0000, wait_n=1 -> mem_ce_n low for 1 cycle, data='h41 driven, m_done[0] at N+2, m_err=0.
REQ-036 DMA read of 'hFF10 with 3 wait cycles -> io_ce_n low for 4 cycles, rdata equals the slave value, m_done[1] at N+5.
REQ-037 Both requesters high continuously for 4 accesses -> grants alternate 0,1,0,1.
REQ-038 wait_n held low -> m_done with m_err=1 after TIMEOUT wait cycles, ce_n released.
REQ-039 Reset asserted during ACCESS -> next edge ce_n=1, data high-Z, no m_done; next request is granted to requester 0.

Source files
------------

// File: rtl/h80cpu_bus_arb_pkg.sv
// h80cpu shared bus package.
// Provides the bus address/data/command types used by the arbiter, its
// decoder and any requester or slave attached to the h80cpu bus.
package h80cpu_bus_arb_pkg;

  typedef logic [15:0] bus_addr_t;
  typedef logic [7:0]  bus_data_t;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'd0,
    CMD_WRITE_B = 2'd1,
    CMD_READ_B  = 2'd2
  } bus_cmd_t;

  function automatic logic cmd_is_write(input bus_cmd_t c);
    return c == CMD_WRITE_B;
  endfunction

endpackage

// File: rtl/h80cpu_bus_arb_if.sv
// Requester-side bundle of the h80cpu bus arbiter.
//   m_req   : per-requester access request (0 = CPU, 1 = DMA/debug)
//   m_addr  : per-requester address
//   m_cmd   : per-requester command
//   m_wdata : per-requester write data
//   m_gnt   : one-hot grant, high while the access is owned
//   m_done  : one-cycle completion pulse to the owner
//   m_err   : timeout abort flag, valid with m_done
//   rdata   : read data, valid with m_done
// modport master : requester view; modport slave : arbiter view.
interface h80cpu_bus_arb_if;
  import h80cpu_bus_arb_pkg::*;

  logic      [1:0] m_req;
  bus_addr_t [1:0] m_addr;
  bus_cmd_t  [1:0] m_cmd;
  bus_data_t [1:0] m_wdata;
  logic      [1:0] m_gnt;
  logic      [1:0] m_done;
  logic            m_err;
  bus_data_t       rdata;

  modport master (
    output m_req, m_addr, m_cmd, m_wdata,
    input  m_gnt, m_done, m_err, rdata
  );

  modport slave (
    input  m_req, m_addr, m_cmd, m_wdata,
    output m_gnt, m_done, m_err, rdata
  );

endinterface

// File: rtl/h80cpu_bus_decode.sv
// Combinational address decoder for the h80cpu bus.
//   i_addr    : bus address
//   o_io_sel  : address lies in the I/O window ((addr & IO_MASK) == IO_BASE)
//   o_mem_sel : address lies in memory space (always the complement of o_io_sel)
module h80cpu_bus_decode
  import h80cpu_bus_arb_pkg::*;
#(
  parameter bus_addr_t IO_BASE = 16'hFF00,
  parameter bus_addr_t IO_MASK = 16'hFF00
) (
  input  bus_addr_t i_addr,
  output logic      o_io_sel,
  output logic      o_mem_sel
);

  assign o_io_sel  = (i_addr & IO_MASK) == IO_BASE;
  assign o_mem_sel = ~o_io_sel;

endmodule

// File: rtl/h80cpu_bus_arb.sv
// Two-requester round-robin arbiter and bus controller for the h80cpu bus.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : requester bundle (h80cpu_bus_arb_if.slave)
//   mem_ce_n   : active-low memory chip enable
//   io_ce_n    : active-low I/O chip enable
//   addr, cmd  : shared slave address / command
//   data       : shared slave data bus (driven only for writes)
//   wait_n     : wired-AND slave ready, low inserts a wait state
// Each access runs IDLE -> ACCESS (one cycle plus waits) -> DONE; all outputs
// are registered, so the minimum access period is three cycles.
module h80cpu_bus_arb
  import h80cpu_bus_arb_pkg::*;
#(
  parameter bus_addr_t   IO_BASE = 16'hFF00,
  parameter bus_addr_t   IO_MASK = 16'hFF00,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  h80cpu_bus_arb_if.slave    bus,
  output logic               mem_ce_n,
  output logic               io_ce_n,
  output bus_addr_t          addr,
  output bus_cmd_t           cmd,
  inout  wire  [7:0]         data,
  input  logic               wait_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t    r_state;
  logic      r_prio;    // requester that wins when both request
  logic      r_owner;
  bus_addr_t r_addr;
  bus_cmd_t  r_cmd;
  bus_data_t r_wdata;
  logic      r_drive;
  logic      r_mem_ce_n;
  logic      r_io_ce_n;
  logic [1:0] r_gnt;
  logic [1:0] r_done;
  logic      r_err;
  bus_data_t r_rdata;
  logic [7:0] r_wcnt;

  logic      w_win;
  bus_addr_t w_win_addr;
  logic      w_io_sel;
  logic      w_mem_sel;
  logic      w_timeout;

  always_comb begin
    w_win = 1'b0;
    if (bus.m_req == 2'b11) w_win = r_prio;
    else if (bus.m_req[1])  w_win = 1'b1;
  end

  assign w_win_addr = bus.m_addr[w_win];

  // Decode the incoming address so chip enables are registered on entry to ACCESS.
  h80cpu_bus_decode #(
    .IO_BASE (IO_BASE),
    .IO_MASK (IO_MASK)
  ) u_decode (
    .i_addr    (w_win_addr),
    .o_io_sel  (w_io_sel),
    .o_mem_sel (w_mem_sel)
  );

  // This low-wait cycle would be the TIMEOUT-th one.
  assign w_timeout = (32'(r_wcnt) + 32'd1) >= TIMEOUT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_cmd      <= CMD_IDLE;
      r_wdata    <= '0;
      r_drive    <= 1'b0;
      r_mem_ce_n <= 1'b1;
      r_io_ce_n  <= 1'b1;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_wcnt     <= '0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (|bus.m_req) begin
            r_state    <= S_ACCESS;
            r_owner    <= w_win;
            r_addr     <= w_win_addr;
            r_cmd      <= bus.m_cmd[w_win];
            r_wdata    <= bus.m_wdata[w_win];
            r_drive    <= cmd_is_write(bus.m_cmd[w_win]);
            r_mem_ce_n <= ~w_mem_sel;
            r_io_ce_n  <= ~w_io_sel;
            r_gnt      <= w_win ? 2'b10 : 2'b01;
            r_wcnt     <= '0;
          end
        end
        S_ACCESS: begin
          if (wait_n || w_timeout) begin
            r_state    <= S_DONE;
            r_mem_ce_n <= 1'b1;
            r_io_ce_n  <= 1'b1;
            r_cmd      <= CMD_IDLE;
            r_drive    <= 1'b0;
            r_done     <= r_owner ? 2'b10 : 2'b01;
            r_err      <= ~wait_n;
            if (wait_n) r_rdata <= data;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_prio  <= ~r_owner;
          r_gnt   <= '0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data        = r_drive ? r_wdata : 'z;
  assign mem_ce_n    = r_mem_ce_n;
  assign io_ce_n     = r_io_ce_n;
  assign addr        = r_addr;
  assign cmd         = r_cmd;
  assign bus.m_gnt   = r_gnt;
  assign bus.m_done  = r_done;
  assign bus.m_err   = r_err;
  assign bus.rdata   = r_rdata;

endmodule

// File: tb/tb_h80cpu_bus_arb.sv
module tb_h80cpu_bus_arb;
  import h80cpu_bus_arb_pkg::*;

  localparam bus_addr_t   TB_IO_BASE = 16'hFF00;
  localparam bus_addr_t   TB_IO_MASK = 16'hFF00;
  localparam int unsigned TB_TIMEOUT = 255;

  logic      clk = 1'b0;
  logic      reset;
  logic      mem_ce_n, io_ce_n;
  bus_addr_t addr;
  bus_cmd_t  cmd;
  wire [7:0] data;
  logic      wait_n;

  // Slave model: returns slv_val on reads; float_en forces a marker value so
  // an unexpected DUT driver shows up as a corrupted bus value.
  logic      float_en;
  bus_data_t slv_val;
  logic      tb_en;
  bus_data_t tb_val;
  assign tb_en  = float_en | ((cmd == CMD_READ_B) & ~(mem_ce_n & io_ce_n));
  assign tb_val = float_en ? 8'h5A : slv_val;
  assign data   = tb_en ? tb_val : 'z;

  h80cpu_bus_arb_if bus_if ();

  h80cpu_bus_arb #(
    .IO_BASE (TB_IO_BASE),
    .IO_MASK (TB_IO_MASK),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .mem_ce_n (mem_ce_n),
    .io_ce_n  (io_ce_n),
    .addr     (addr),
    .cmd      (cmd),
    .data     (data),
    .wait_n   (wait_n)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [1:0]  req;
    bus_addr_t   a0, a1;
    bus_cmd_t    c0, c1;
    bus_data_t   w0, w1;
    int unsigned waits;
    bus_data_t   sval;
    logic        own;
    logic        io;
    logic        err;
    bus_data_t   rd;
  } vec_t;

  // Reference model state: who wins a tie, and the last rdata value.
  logic      m_prio;
  bus_data_t m_rdata;

  function automatic void model_fill(inout vec_t v);
    bus_addr_t a;
    bus_cmd_t  c;
    bus_data_t w;
    v.own = (v.req == 2'b11) ? m_prio : v.req[1];
    a = v.own ? v.a1 : v.a0;
    c = v.own ? v.c1 : v.c0;
    w = v.own ? v.w1 : v.w0;
    v.io  = (a & TB_IO_MASK) == TB_IO_BASE;
    v.err = v.waits >= TB_TIMEOUT;
    v.rd  = v.err ? m_rdata : ((c == CMD_WRITE_B) ? w : v.sval);
    m_prio  = ~v.own;
    m_rdata = v.rd;
  endfunction

  // Drive one request from IDLE and check every cycle through DONE and back to IDLE.
  task automatic run_txn(input vec_t v);
    logic [1:0]  oh;
    int unsigned acc;
    bus_cmd_t    ec;
    bus_addr_t   ea;
    bus_data_t   ew;
    oh  = v.own ? 2'b10 : 2'b01;
    ec  = v.own ? v.c1 : v.c0;
    ea  = v.own ? v.a1 : v.a0;
    ew  = v.own ? v.w1 : v.w0;
    acc = v.err ? TB_TIMEOUT : v.waits + 1;
    bus_if.m_req      = v.req;
    bus_if.m_addr[0]  = v.a0;
    bus_if.m_addr[1]  = v.a1;
    bus_if.m_cmd[0]   = v.c0;
    bus_if.m_cmd[1]   = v.c1;
    bus_if.m_wdata[0] = v.w0;
    bus_if.m_wdata[1] = v.w1;
    slv_val = v.sval;
    wait_n  = 1'b1;
    @(negedge clk);
    bus_if.m_req = 2'b00;
    for (int unsigned j = 0; j < acc; j++) begin
      wait_n = (j == v.waits);
      chk("acc_gnt", 32'(bus_if.m_gnt), 32'(oh));
      chk("acc_done", 32'(bus_if.m_done), 32'd0);
      chk("acc_mem_ce_n", 32'(mem_ce_n), 32'(v.io));
      chk("acc_io_ce_n", 32'(io_ce_n), 32'(!v.io));
      chk("acc_cmd", 32'(cmd), 32'(ec));
      chk("acc_addr", 32'(addr), 32'(ea));
      if (ec == CMD_WRITE_B) chk("acc_wdata", 32'(data), 32'(ew));
      @(negedge clk);
    end
    wait_n = 1'b1;
    chk("done_pulse", 32'(bus_if.m_done), 32'(oh));
    chk("done_err", 32'(bus_if.m_err), 32'(v.err));
    chk("done_rdata", 32'(bus_if.rdata), 32'(v.rd));
    chk("done_gnt", 32'(bus_if.m_gnt), 32'(oh));
    chk("done_ce", 32'({mem_ce_n, io_ce_n}), 32'b11);
    chk("done_cmd", 32'(cmd), 32'(CMD_IDLE));
    float_en = 1'b1;
    #1;
    chk("done_data_z", 32'(data), 32'h5A);
    @(negedge clk);
    float_en = 1'b0;
    chk("idle_gnt", 32'(bus_if.m_gnt), 32'd0);
    chk("idle_done", 32'(bus_if.m_done), 32'd0);
    chk("idle_err", 32'(bus_if.m_err), 32'd0);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Hand-derived vectors applied in order; priority evolves 0 -> 1 -> 0 ...
    tbl[0] = '{2'b01, 16'h0000, 16'h0000, CMD_WRITE_B, CMD_IDLE,    8'h41, 8'h00, 0,              8'h00, 1'b0, 1'b0, 1'b0, 8'h41};
    tbl[1] = '{2'b10, 16'h0000, 16'hFF10, CMD_IDLE,    CMD_READ_B,  8'h00, 8'h00, 3,              8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3};
    tbl[2] = '{2'b11, 16'h1234, 16'hFF00, CMD_READ_B,  CMD_WRITE_B, 8'h00, 8'hAA, 0,              8'h77, 1'b0, 1'b0, 1'b0, 8'h77};
    tbl[3] = '{2'b11, 16'hFF80, 16'h8000, CMD_WRITE_B, CMD_READ_B,  8'h12, 8'h00, 1,              8'h99, 1'b1, 1'b0, 1'b0, 8'h99};
    tbl[4] = '{2'b01, 16'hFEFF, 16'h0000, CMD_READ_B,  CMD_IDLE,    8'h00, 8'h00, TB_TIMEOUT - 1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
    tbl[5] = '{2'b10, 16'h0000, 16'hFFFF, CMD_IDLE,    CMD_READ_B,  8'h00, 8'h00, TB_TIMEOUT,     8'hD2, 1'b1, 1'b1, 1'b1, 8'h3C};
    tbl[6] = '{2'b01, 16'hFF00, 16'h0000, CMD_READ_B,  CMD_IDLE,    8'h00, 8'h00, 1,              8'hE7, 1'b0, 1'b1, 1'b0, 8'hE7};

    reset = 1'b1;
    wait_n = 1'b1;
    float_en = 1'b0;
    slv_val = 8'h00;
    bus_if.m_req = 2'b00;
    bus_if.m_addr = '0;
    bus_if.m_cmd[0] = CMD_IDLE;
    bus_if.m_cmd[1] = CMD_IDLE;
    bus_if.m_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_ce", 32'({mem_ce_n, io_ce_n}), 32'b11);
    chk("rst_cmd", 32'(cmd), 32'(CMD_IDLE));
    chk("rst_gnt", 32'(bus_if.m_gnt), 32'd0);
    chk("rst_done", 32'(bus_if.m_done), 32'd0);
    chk("rst_err", 32'(bus_if.m_err), 32'd0);
    chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
    float_en = 1'b1;
    #1;
    chk("rst_data_z", 32'(data), 32'h5A);
    float_en = 1'b0;

    // Both requesters held high: grants alternate 0,1,0,1 with a 3-cycle period.
    bus_if.m_req = 2'b11;
    bus_if.m_addr[0] = 16'h0010;
    bus_if.m_addr[1] = 16'h0020;
    bus_if.m_cmd[0] = CMD_READ_B;
    bus_if.m_cmd[1] = CMD_READ_B;
    for (int k = 1; k <= 12; k++) begin
      int ph;
      logic [1:0] oh;
      @(negedge clk);
      ph = (k - 1) % 3;
      oh = (((k - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01;
      chk("rr_gnt", 32'(bus_if.m_gnt), (ph == 2) ? 32'd0 : 32'(oh));
      chk("rr_done", 32'(bus_if.m_done), (ph == 1) ? 32'(oh) : 32'd0);
      if (k == 10) bus_if.m_req = 2'b00;
    end

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset during ACCESS: owner 1 (priority went to 1 after the last CPU access).
    bus_if.m_req = 2'b11;
    bus_if.m_addr[0] = 16'h0100;
    bus_if.m_addr[1] = 16'hFF20;
    bus_if.m_cmd[0] = CMD_WRITE_B;
    bus_if.m_cmd[1] = CMD_WRITE_B;
    bus_if.m_wdata[0] = 8'h11;
    bus_if.m_wdata[1] = 8'h22;
    wait_n = 1'b0;
    @(negedge clk);
    chk("ra_gnt", 32'(bus_if.m_gnt), 32'b10);
    chk("ra_io_ce_n", 32'(io_ce_n), 32'd0);
    chk("ra_data", 32'(data), 32'h22);
    bus_if.m_req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ra_ce", 32'({mem_ce_n, io_ce_n}), 32'b11);
    chk("ra_gnt0", 32'(bus_if.m_gnt), 32'd0);
    chk("ra_done", 32'(bus_if.m_done), 32'd0);
    chk("ra_cmd", 32'(cmd), 32'(CMD_IDLE));
    chk("ra_rdata", 32'(bus_if.rdata), 32'd0);
    float_en = 1'b1;
    #1;
    chk("ra_data_z", 32'(data), 32'h5A);
    float_en = 1'b0;
    reset = 1'b0;
    wait_n = 1'b1;
    @(negedge clk);
    chk("ra_no_done", 32'(bus_if.m_done), 32'd0);
    rv = '{2'b11, 16'h0200, 16'hFF30, CMD_READ_B, CMD_READ_B, 8'h00, 8'h00, 0, 8'h5C, 1'b0, 1'b0, 1'b0, 8'h5C};
    run_txn(rv);

    // Randomised accesses against the reference model, from a fresh reset.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_prio = 1'b0;
    m_rdata = 8'h00;
    for (int n = 0; n < 40; n++) begin
      rv.req   = 2'($urandom_range(1, 3));
      rv.a0    = ($urandom_range(0, 1) == 1) ? {8'hFF, 8'($urandom)} : 16'($urandom);
      rv.a1    = ($urandom_range(0, 1) == 1) ? {8'hFF, 8'($urandom)} : 16'($urandom);
      rv.c0    = ($urandom_range(0, 1) == 1) ? CMD_WRITE_B : CMD_READ_B;
      rv.c1    = ($urandom_range(0, 1) == 1) ? CMD_WRITE_B : CMD_READ_B;
      rv.w0    = 8'($urandom);
      rv.w1    = 8'($urandom);
      rv.waits = $urandom_range(0, 4);
      rv.sval  = 8'($urandom);
      model_fill(rv);
      run_txn(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
